// File: rtl/mult_digit_seq.sv
// Sequential unsigned multiplier: one 2x2-bit digit product is accumulated per
// clock, walking every (a_i, b_j) digit pair of the captured operands.
module mult_digit_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic                 abort,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   P,
  output logic                 busy
);

  localparam int N  = WIDTH / 2;
  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        i_q, i_d, j_q, j_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d, p_q, p_d;

  logic [1:0]           a_dig, b_dig;
  logic [3:0]           dig_prod;
  logic [IW:0]          pos_sum;
  logic [IW+1:0]        shamt;
  logic [2*WIDTH-1:0]   term, acc_next;

  // Digit pair (i, j) is the flat index k = i*N + j; i and j are kept as
  // separate counters so no divider is needed for odd digit counts.
  always_comb begin
    a_dig    = 2'(a_q >> {i_q, 1'b0});
    b_dig    = 2'(b_q >> {j_q, 1'b0});
    dig_prod = {2'b00, a_dig} * {2'b00, b_dig};
    pos_sum  = {1'b0, i_q} + {1'b0, j_q};
    shamt    = {pos_sum, 1'b0};
    term     = (2*WIDTH)'(dig_prod) << shamt;
    acc_next = acc_q + term;
  end

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    p_d      = p_q;
    in_ready = (state_q == S_IDLE) && !abort && !rst;

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = A;
          b_d     = B;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
          acc_d   = '0;
          p_d     = '0;
          i_d     = '0;
          j_d     = '0;
        end else begin
          acc_d = acc_next;
          if (j_q == LAST) begin
            j_d = '0;
            if (i_q == LAST) begin
              i_d     = '0;
              p_d     = acc_next;
              state_d = S_DONE;
            end else begin
              i_d = i_q + IW'(1);
            end
          end else begin
            j_d = j_q + IW'(1);
          end
        end
      end
      S_DONE: begin
        if (abort) begin
          state_d = S_IDLE;
          acc_d   = '0;
          p_d     = '0;
        end else if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
    end
  end

  assign busy      = (state_q == S_RUN);
  assign out_valid = (state_q == S_DONE);
  assign P         = p_q;

endmodule

// File: tb/tb_mult_digit_seq.sv
// Directed bench for mult_digit_seq: an 8-bit instance for the protocol
// scenarios and a 16-bit instance for the wide-operand sweep.
module tb_mult_digit_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0, abort = 1'b0, out_ready = 1'b1;
  logic [7:0]  A = '0, B = '0;
  logic        in_ready, out_valid, busy;
  logic [15:0] P;

  logic        in_valid_w = 1'b0, abort_w = 1'b0, out_ready_w = 1'b1;
  logic [15:0] A_w = '0, B_w = '0;
  logic        in_ready_w, out_valid_w, busy_w;
  logic [31:0] P_w;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mult_digit_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .abort(abort), .out_valid(out_valid),
    .out_ready(out_ready), .P(P), .busy(busy)
  );

  mult_digit_seq #(.WIDTH(16)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid_w), .in_ready(in_ready_w),
    .A(A_w), .B(B_w), .abort(abort_w), .out_valid(out_valid_w),
    .out_ready(out_ready_w), .P(P_w), .busy(busy_w)
  );

  // Waits for in_ready, performs one handshake, then scrambles A/B so a
  // design that fails to capture operands produces a wrong product.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL start_ready: in_ready=%b want 1", in_ready);
    end
    A = a; B = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    A = 8'($urandom); B = 8'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 200);
  endtask

  task automatic test_reset;
    #2 rst = 1'b1;
    #1;
    total++;
    if ({in_ready, out_valid, busy} !== 3'b000 || P !== 16'h0) begin
      bad++;
      $display("FAIL reset_outputs: rdy/vld/busy=%b P=%h want 000 P=0000", {in_ready, out_valid, busy}, P);
    end
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready_held: in_ready=%b want 0", in_ready);
    end
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: in_ready=%b busy=%b want 1 0", in_ready, busy);
    end
  endtask

  task automatic test_max;
    int lat;
    out_ready = 1'b1;
    start_op(8'hFF, 8'hFF);
    total++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL max_run_flags: busy=%b in_ready=%b want 1 0", busy, in_ready);
    end
    wait_done(lat);
    total++;
    if (lat !== 16) begin
      bad++;
      $display("FAIL max_latency: got %0d want 16", lat);
    end
    total++;
    if (P !== 16'hFE01 || busy !== 1'b0) begin
      bad++;
      $display("FAIL max_product: P=%h busy=%b want FE01 0", P, busy);
    end
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || P !== 16'hFE01) begin
      bad++;
      $display("FAIL max_to_idle: vld=%b rdy=%b P=%h want 0 1 FE01", out_valid, in_ready, P);
    end
  endtask

  task automatic test_hold;
    int lat;
    out_ready = 1'b0;
    start_op(8'h0D, 8'h0B);
    wait_done(lat);
    total++;
    if (lat !== 16 || P !== 16'h008F) begin
      bad++;
      $display("FAIL hold_done: lat=%0d P=%h want 16 008F", lat, P);
    end
    for (int c = 0; c < 5; c++) begin
      in_valid = c[0];
      A = 8'h77; B = 8'h66;
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || P !== 16'h008F || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL hold_stable[%0d]: vld=%b P=%h rdy=%b want 1 008F 0", c, out_valid, P, in_ready);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || P !== 16'h008F) begin
      bad++;
      $display("FAIL hold_release: vld=%b busy=%b P=%h want 0 0 008F", out_valid, busy, P);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    out_ready = 1'b1;
    start_op(8'h37, 8'h00);
    wait_done(lat);
    total++;
    if (lat !== 16 || P !== 16'h0000) begin
      bad++;
      $display("FAIL b2b_first: lat=%0d P=%h want 16 0000", lat, P);
    end
    A = 8'h00; B = 8'hA5; in_valid = 1'b1;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_no_overlap: busy=%b rdy=%b want 0 1", busy, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    A = 8'hFF; B = 8'hFF;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_second_accept: busy=%b want 1", busy);
    end
    wait_done(lat);
    total++;
    if (lat !== 16 || P !== 16'h0000) begin
      bad++;
      $display("FAIL b2b_second: lat=%0d P=%h want 16 0000", lat, P);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_abort;
    int lat;
    bit seen;
    out_ready = 1'b1;
    start_op(8'h12, 8'h34);
    repeat (7) begin
      @(posedge clk); #1;
    end
    abort = 1'b1;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || P !== 16'h0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL abort_run: busy=%b vld=%b P=%h rdy=%b want 0 0 0000 0", busy, out_valid, P, in_ready);
    end
    in_valid = 1'b1;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_blocks_accept: busy=%b want 0", busy);
    end
    in_valid = 1'b0;
    abort = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL abort_ready_back: in_ready=%b want 1", in_ready);
    end
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL abort_no_product: out_valid seen=%b want 0", seen);
    end
    start_op(8'h12, 8'h34);
    wait_done(lat);
    total++;
    if (lat !== 16 || P !== 16'h03A8) begin
      bad++;
      $display("FAIL abort_rerun: lat=%0d P=%h want 16 03A8", lat, P);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset;
    bit seen;
    out_ready = 1'b1;
    start_op(8'hFF, 8'h01);
    repeat (5) begin
      @(posedge clk); #1;
    end
    #3 rst = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || P !== 16'h0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: busy=%b vld=%b P=%h rdy=%b want 0 0 0000 0", busy, out_valid, P, in_ready);
    end
    #2 rst = 1'b0;
    seen = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL async_reset_discard: vld seen=%b rdy=%b want 0 1", seen, in_ready);
    end
  endtask

  task automatic test_wide;
    logic [15:0] wa, wb;
    logic [31:0] expv;
    int lat;
    out_ready_w = 1'b1;
    for (int t = 0; t < 400; t++) begin
      if (t == 0) begin
        wa = 16'hFFFF; wb = 16'hFFFF;
      end else begin
        wa = 16'($urandom); wb = 16'($urandom);
      end
      expv = 32'(wa) * 32'(wb);
      A_w = wa; B_w = wb; in_valid_w = 1'b1;
      @(posedge clk); #1;
      in_valid_w = 1'b0;
      A_w = ~wa; B_w = ~wb;
      lat = 0;
      do begin
        @(posedge clk); #1;
        lat++;
      end while (!out_valid_w && lat < 200);
      total++;
      if (lat !== 64) begin
        bad++;
        $display("FAIL wide_latency[%0d]: got %0d want 64", t, lat);
      end
      total++;
      if (P_w !== expv) begin
        bad++;
        $display("FAIL wide_product[%0d]: %h*%h P=%h want %h", t, wa, wb, P_w, expv);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_max();
    test_hold();
    test_back_to_back();
    test_abort();
    test_async_reset();
    test_wide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
